// File: rtl/round_robin_distributor_if.sv
// Bundle between the single producer / four consumers and the distributor.
// Producer side drives wen/din, consumer side drives ren; the distributor
// returns the registered read word, its one-hot owner, status flags and a
// debug view of its internal occupancy and priority pointer.
//
// Handshake: a write is taken on any rising edge with wen=1 while full=0;
// with full=1 the word is dropped and wr_error pulses on the next cycle.
// A read is taken on any rising edge with ren!=0 while empty=0; exactly
// one requesting channel wins and sees its valid bit (with dout) during
// the following cycle. Losers get nothing and must keep ren raised.
interface round_robin_distributor_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wen;
    logic [DW-1:0] din;
    logic [3:0]    ren;
    logic [DW-1:0] dout;
    logic [3:0]    valid;
    logic          full;
    logic          empty;
    logic          wr_error;
    logic          rd_error;
    logic [CW-1:0] dbg_count;
    logic [1:0]    dbg_prio;

    // Producer/consumer side.
    modport master (
        output wen, din, ren,
        input  dout, valid, full, empty, wr_error, rd_error, dbg_count, dbg_prio
    );

    // Distributor side.
    modport slave (
        input  wen, din, ren,
        output dout, valid, full, empty, wr_error, rd_error, dbg_count, dbg_prio
    );
endinterface

// File: rtl/round_robin_distributor.sv
// One write stream buffered in a small FIFO and handed out, one word per
// cycle, to whichever of four requesting consumers currently holds the
// rotating priority. Word order is global: successive pops return words
// in write order no matter which channel receives them.
module round_robin_distributor #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    round_robin_distributor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage is never cleared; pointers and count define what is live.
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    prio;

    logic [DW-1:0] dout_q;
    logic [3:0]    valid_q;
    logic          wr_error_q;
    logic          rd_error_q;

    logic          full_c;
    logic          empty_c;
    logic          any_req;
    logic          do_push;
    logic          do_pop;
    logic [1:0]    grant;
    logic          grant_found;
    logic [CW-1:0] count_nxt;

    // Occupancy flags and the accept decisions, all from pre-edge count.
    always_comb begin
        full_c  = (count == CW'(DEPTH));
        empty_c = (count == '0);
        any_req = |bus.ren;
        do_pop  = any_req && !empty_c;
        // A full FIFO rejects a write even if a pop frees a slot this edge.
        do_push = bus.wen && !full_c;
    end

    // Rotating-priority search: first requester starting at prio.
    always_comb begin
        grant       = prio;
        grant_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!grant_found && bus.ren[prio + 2'(k)]) begin
                grant       = prio + 2'(k);
                grant_found = 1'b1;
            end
        end
    end

    // Next occupancy: push and pop in the same edge cancel out.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Data array write; the pushed word only becomes visible next edge.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers, occupancy and priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                prio   <= grant + 2'd1;
            end
            count <= count_nxt;
        end
    end

    // Registered read port and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            valid_q    <= '0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            if (do_pop) begin
                dout_q  <= mem[rd_ptr];
                valid_q <= 4'b0001 << grant;
            end else begin
                dout_q  <= '0;
                valid_q <= '0;
            end
            rd_error_q <= any_req && empty_c;
            wr_error_q <= bus.wen && full_c;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.dout      = dout_q;
        bus.valid     = valid_q;
        bus.full      = full_c;
        bus.empty     = empty_c;
        bus.wr_error  = wr_error_q;
        bus.rd_error  = rd_error_q;
        bus.dbg_count = count;
        bus.dbg_prio  = prio;
    end
endmodule

// File: tb/tb_round_robin_distributor.sv
// Bench for round_robin_distributor: a constant vector table for the
// directed scenarios, hand sequences for full/wrap corners, then random
// traffic against a queue-based reference model.
module tb_round_robin_distributor;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    round_robin_distributor_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    round_robin_distributor #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;

    // Reference model: a plain queue of stored words plus the priority channel.
    logic [DW-1:0] mq[$];
    int            m_prio;
    logic [DW-1:0] m_dout;
    logic [3:0]    m_valid;
    logic          m_wr_err;
    logic          m_rd_err;

    function automatic void model_step(input logic r, input logic w,
                                       input logic [DW-1:0] d, input logic [3:0] rq);
        int pre;
        int ch;
        if (r) begin
            mq.delete();
            m_prio   = 0;
            m_dout   = '0;
            m_valid  = '0;
            m_wr_err = 1'b0;
            m_rd_err = 1'b0;
            return;
        end
        pre      = mq.size();
        m_dout   = '0;
        m_valid  = '0;
        m_rd_err = 1'b0;
        m_wr_err = 1'b0;
        if (rq != 0) begin
            if (pre > 0) begin
                ch = -1;
                for (int i = 0; i < 4; i++) begin
                    if (ch < 0 && rq[(m_prio + i) % 4]) ch = (m_prio + i) % 4;
                end
                m_dout  = mq.pop_front();
                m_valid = 4'(1 << ch);
                m_prio  = (ch + 1) % 4;
            end else begin
                m_rd_err = 1'b1;
            end
        end
        if (w) begin
            if (pre < DEPTH) mq.push_back(d);
            else             m_wr_err = 1'b1;
        end
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Driver: apply inputs, clock once, advance the model, sample 1 time unit later.
    task automatic drive(input logic r, input logic w, input logic [DW-1:0] d,
                         input logic [3:0] rq);
        rst     = r;
        bus.wen = w;
        bus.din = d;
        bus.ren = rq;
        @(posedge clk);
        model_step(r, w, d, rq);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dout"},     32'(bus.dout),      32'(m_dout));
        check({tag, ".valid"},    32'(bus.valid),     32'(m_valid));
        check({tag, ".wr_error"}, 32'(bus.wr_error),  32'(m_wr_err));
        check({tag, ".rd_error"}, 32'(bus.rd_error),  32'(m_rd_err));
        check({tag, ".full"},     32'(bus.full),      32'(mq.size() == DEPTH));
        check({tag, ".empty"},    32'(bus.empty),     32'(mq.size() == 0));
        check({tag, ".count"},    32'(bus.dbg_count), 32'(mq.size()));
    endtask

    typedef struct {
        logic          rst;
        logic          wen;
        logic [DW-1:0] din;
        logic [3:0]    ren;
        logic [DW-1:0] e_dout;
        logic [3:0]    e_valid;
        logic          e_wr_err;
        logic          e_rd_err;
        logic          e_full;
        logic          e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic w, input logic [DW-1:0] d,
                                    input logic [3:0] rq, input logic [DW-1:0] ed,
                                    input logic [3:0] ev, input logic ewe, input logic ere,
                                    input logic ef, input logic ee);
        vec_t v;
        v.rst = r; v.wen = w; v.din = d; v.ren = rq;
        v.e_dout = ed; v.e_valid = ev; v.e_wr_err = ewe; v.e_rd_err = ere;
        v.e_full = ef; v.e_empty = ee;
        vecs.push_back(v);
    endfunction

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst     = 1'b1;
        bus.wen = 1'b0;
        bus.din = '0;
        bus.ren = '0;
        m_prio  = 0;
        m_dout  = '0;
        m_valid = '0;
        m_wr_err = 1'b0;
        m_rd_err = 1'b0;

        //        rst wen din    ren      dout   valid    we re full empty
        // reset held two cycles while writes and reads are requested
        add_vec(1, 1, 8'h55, 4'hF,    8'h00, 4'b0000, 0, 0, 0, 1);
        add_vec(1, 1, 8'h55, 4'hF,    8'h00, 4'b0000, 0, 0, 0, 1);
        add_vec(0, 0, 8'h00, 4'b0001, 8'h00, 4'b0000, 0, 1, 0, 1);
        // rotation across all four channels
        add_vec(0, 1, 8'h10, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h11, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h12, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h13, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b1111, 8'h10, 4'b0001, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b1111, 8'h11, 4'b0010, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b1111, 8'h12, 4'b0100, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b1111, 8'h13, 4'b1000, 0, 0, 0, 1);
        add_vec(0, 0, 8'h00, 4'b1111, 8'h00, 4'b0000, 0, 1, 0, 1);
        // one grant to ch0 moves priority to ch1, then non-requesters are skipped
        add_vec(0, 1, 8'h55, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b0001, 8'h55, 4'b0001, 0, 0, 0, 1);
        add_vec(0, 1, 8'hA0, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'hA1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b1001, 8'hA0, 4'b1000, 0, 0, 0, 0);
        add_vec(0, 0, 8'h00, 4'b1001, 8'hA1, 4'b0001, 0, 0, 0, 1);
        // reset mid-stream with five words stored and a request pending
        add_vec(0, 1, 8'h21, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h22, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h23, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h24, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 1, 8'h25, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 0);
        add_vec(1, 0, 8'h00, 4'b0010, 8'h00, 4'b0000, 0, 0, 0, 1);
        add_vec(0, 0, 8'h00, 4'b0010, 8'h00, 4'b0000, 0, 1, 0, 1);

        // Table phase: compared against the constants above.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wen, vecs[i].din, vecs[i].ren);
            check($sformatf("vec%0d.dout", i),     32'(bus.dout),     32'(vecs[i].e_dout));
            check($sformatf("vec%0d.valid", i),    32'(bus.valid),    32'(vecs[i].e_valid));
            check($sformatf("vec%0d.wr_error", i), 32'(bus.wr_error), 32'(vecs[i].e_wr_err));
            check($sformatf("vec%0d.rd_error", i), 32'(bus.rd_error), 32'(vecs[i].e_rd_err));
            check($sformatf("vec%0d.full", i),     32'(bus.full),     32'(vecs[i].e_full));
            check($sformatf("vec%0d.empty", i),    32'(bus.empty),    32'(vecs[i].e_empty));
        end

        // Full: eight words fill, the ninth is rejected and never stored.
        drive(1, 0, 8'h00, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 8'(i), 4'b0000);
            check_model("fill");
            if (i == 7) check("full_after_8", 32'(bus.full), 32'd1);
            if (i == 8) check("wr_error_9th", 32'(bus.wr_error), 32'd1);
        end
        drive(0, 0, 8'h00, 4'b0000);
        check("wr_error_one_cycle", 32'(bus.wr_error), 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 8'h00, 4'b0001);
            check_model("drain");
            if (i < 8) check($sformatf("drain_word%0d", i), 32'(bus.dout), 32'(i));
            else       check("drain_no_08", 32'(bus.valid), 32'd0);
        end

        // Full with simultaneous push and pop: pop succeeds, push is dropped.
        for (int i = 0; i < 8; i++) drive(0, 1, 8'(8'h30 + i), 4'b0000);
        drive(0, 1, 8'hFF, 4'b0100);
        check_model("full_pushpop");
        check("fp_valid", 32'(bus.valid), 32'b0100);
        check("fp_dout", 32'(bus.dout), 32'h30);
        check("fp_wr_error", 32'(bus.wr_error), 32'd1);
        check("fp_count", 32'(bus.dbg_count), 32'd7);
        for (int i = 1; i < 9; i++) begin
            drive(0, 0, 8'h00, 4'b0100);
            check_model("fp_drain");
            if (i < 8) check($sformatf("fp_word%0d", i), 32'(bus.dout), 32'(8'h30 + i));
        end

        // Push+pop at count 4 across three pointer wraps.
        for (int i = 0; i < 4; i++) drive(0, 1, 8'(8'h40 + i), 4'b0000);
        for (int i = 0; i < 24; i++) begin
            drive(0, 1, 8'(8'h44 + i), 4'($urandom_range(1, 15)));
            check_model("steady");
            check("steady_count", 32'(bus.dbg_count), 32'd4);
            check("steady_dout", 32'(bus.dout), 32'(8'h40 + i));
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 8'h00, 4'b1000);
            check_model("steady_drain");
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic w;
            logic [3:0] rq;
            r  = ($urandom_range(0, 199) == 0);
            if (i < 1500) w = ($urandom_range(0, 3) != 0);
            else          w = ($urandom_range(0, 3) == 0);
            rq = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            drive(r, w, 8'($urandom), rq);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/round_robin_distributor.md
Name: round_robin_distributor

Overview:
- Single-producer to four-consumer splitter; the inverse of the four-into-one round-robin merge.
- One 8-bit write stream is buffered in an internal 8-entry FIFO.
- Four consumer channels raise per-channel read requests.
- A rotating-priority grant hands each popped word to exactly one requesting channel per cycle, tagged by a one-hot valid.

Parameters:
- DW, 8, data width in bits.
- DEPTH, 8, FIFO entries (power of two); count width is log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wen  input  1  write request; din is pushed when accepted.
- din  input  DW  write data.
- ren  input  4  per-channel read request; bit i belongs to consumer i.
- dout  output  DW  registered read data; 0 when no valid bit is set.
- valid  output  4  registered one-hot; bit i marks dout as belonging to channel i. All-zero when no word is delivered.
- full  output  1  combinational, count == DEPTH.
- empty  output  1  combinational, count == 0.
- wr_error  output  1  registered one-cycle pulse: write rejected because full.
- rd_error  output  1  registered one-cycle pulse: request(s) present but FIFO empty.

Behaviour:
- Reset is synchronous: when rst=1 at a clock edge, the following are cleared to 0:
  - wr_ptr, rd_ptr, count, prio
  - dout, valid, wr_error, rd_error
- FIFO contents are not cleared. Reset mid-stream discards all stored words and cancels any grant on that edge.
- Reset dominates wen and ren.
- State:
  - prio is a 2-bit rotating pointer naming the highest-priority channel.
  - Grant search order is prio, prio+1, prio+2, prio+3 (mod 4).
  - The grant is the first channel with ren set; it is combinational.
- Read, evaluated with count before the edge:
  - Any ren and count>0: pop mem[rd_ptr] into dout, set valid to one-hot(grant), rd_ptr+1 (wraps DEPTH-1 -> 0), prio <= grant+1 (mod 4), rd_error <= 0.
  - Any ren and count==0: dout <= 0, valid <= 0, rd_error <= 1, prio and rd_ptr unchanged.
  - ren==0: dout <= 0, valid <= 0, rd_error <= 0, prio unchanged.
- Read latency is 1 cycle: a request at edge N yields data during the cycle after edge N.
- Ungranted requesters receive nothing that cycle. They must hold ren to be served later; nothing is queued per channel.
- Write, evaluated with count before the edge:
  - wen and count<DEPTH: mem[wr_ptr] <= din, wr_ptr+1 (wraps), wr_error <= 0.
  - wen and count==DEPTH: word dropped, pointers unchanged, wr_error <= 1. This holds even if a pop occurs the same edge; there is no full-bypass.
  - wen==0: wr_error <= 0.
- Simultaneous push and pop when 0<count<DEPTH: both succeed, count unchanged. Pointers stay independent, so the pushed word cannot be read the same edge.
- Push into an empty FIFO with a concurrent request: the read fails (rd_error=1); the word is readable from the next edge. There is no write-to-read bypass.
- count update:
  - +1 on successful push only.
  - -1 on successful pop only.
  - Otherwise unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Exactly one valid bit at most is set in any cycle. dout is 0 whenever valid==0.
- Word order is preserved globally: consecutive pops return words in write order, regardless of which channel receives them.

Test Plan:
- Reset: hold rst=1 for 2 cycles with wen=1, ren=4'hF -> all outputs 0, empty=1, full=0; the first read after release gives rd_error=1, valid=0.
- Rotation: push 8'h10..8'h13, then hold ren=4'b1111 for 4 cycles -> valid=0001/0010/0100/1000 with dout=10/11/12/13; the 5th cycle gives rd_error=1.
- Skip non-requesters: with prio=1 (after one grant to ch0), push 8'hA0, 8'hA1, ren=4'b1001 -> ch3 gets A0, then ch0 gets A1 (prio wraps 0).
- Full: push 9 words 8'h00..8'h08 -> full=1 after the 8th; the 9th gives wr_error=1 for one cycle. Draining with ren=4'b0001 returns 00..07 only, and the 8'h08 push did not land.
- Full plus simultaneous push/pop: at count=8 assert wen (din=8'hFF) and ren=4'b0100 -> ch2 gets the oldest word, wr_error=1, count=7, FF never read. At count=4, push+pop leaves count=4 and ordering intact across 3 pointer wraps.
- Reset mid-stream: with count=5, assert rst for 1 cycle while ren=4'b0010 -> valid=0 the next cycle, empty=1; old data is never delivered.
